shift_cmd_seq: RTL and testbench

Command sequencer that sits directly upstream of the `shifts` unit. It accepts one shift command at a time (data, op, repeat count) over a valid/ready handshake. It then drives the shifter's `go_data`/`op` inputs, feeding each registered `get_data` back in until the count is exhausted. The final value is returned on a result handshake, so multi-step shifts/rotates need no external control.

---
 rtl/shift_pkg.sv | 17 +
 rtl/lat_counter.sv | 31 +++
 rtl/shift_cmd_seq.sv | 134 +++++++++++++
 tb/tb_shift_cmd_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the shift command sequencer.
package shift_pkg;

  localparam int W_DEF = 4;

  localparam logic [2:0] OP_NOP_C = 3'b000;
  localparam logic [2:0] OP_ROL   = 3'b010;
  localparam logic [2:0] OP_ROR   = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter timing the shifter latency.
module lat_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/shift_cmd_seq.sv
// Sequencer that repeats one shifter op cmd_count times
// and returns the final operand on a result handshake.
module shift_cmd_seq
  import shift_pkg::*;
#(
  parameter int         W         = W_DEF,
  parameter int         CW        = 3,
  parameter int         SHIFT_LAT = 1,
  parameter logic [2:0] OP_NOP    = OP_NOP_C
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [W-1:0]  cmd_data,
  input  logic [2:0]    cmd_op,
  input  logic [CW-1:0] cmd_count,
  output logic [W-1:0]  go_data,
  output logic [2:0]    op,
  input  logic [W-1:0]  get_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_data
);

  localparam int LW = 2;

  state_e        state_q, state_d;
  logic [W-1:0]  opnd_q, opnd_d;
  logic [2:0]    op_r_q, op_r_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [W-1:0]  go_data_q, go_data_d;
  logic [2:0]    op_q, op_d;
  logic          res_valid_q, res_valid_d;
  logic [W-1:0]  res_data_q, res_data_d;
  logic          lat_load;
  logic          lat_zero;

  lat_counter #(.WIDTH(LW)) u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (lat_load),
    .load_val (LW'(SHIFT_LAT - 1)),
    .zero     (lat_zero)
  );

  always_comb begin
    state_d     = state_q;
    opnd_d      = opnd_q;
    op_r_d      = op_r_q;
    rem_d       = rem_q;
    go_data_d   = go_data_q;
    op_d        = OP_NOP;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    lat_load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          opnd_d = cmd_data;
          op_r_d = cmd_op;
          rem_d  = cmd_count;
          if (cmd_count == '0) begin
            state_d     = DONE;
            res_valid_d = 1'b1;
            res_data_d  = cmd_data;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        lat_load = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (lat_zero) begin
          opnd_d = get_data;
          if (rem_q != '0) rem_d = rem_q - 1'b1;
          if (rem_q <= CW'(1)) begin
            state_d     = DONE;
            res_valid_d = 1'b1;
            res_data_d  = get_data;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so the step is staged on entry to ISSUE
    if (state_d == ISSUE) begin
      go_data_d = opnd_d;
      op_d      = op_r_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      opnd_q      <= '0;
      op_r_q      <= OP_NOP;
      rem_q       <= '0;
      go_data_q   <= '0;
      op_q        <= OP_NOP;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      opnd_q      <= opnd_d;
      op_r_q      <= op_r_d;
      rem_q       <= rem_d;
      go_data_q   <= go_data_d;
      op_q        <= op_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign go_data   = go_data_q;
  assign op        = op_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_shift_cmd_seq.sv
// Bench: two sequencers (latency 1 and 3) on stub rotate shifters.
module tb_shift_cmd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      cv, cr, rv, rr;
  logic [1:0][3:0] cd, gd, gt, rd;
  logic [1:0][2:0] co, cc, opo;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit started = 0;
  int nissue[2] = '{0, 0};

  shift_cmd_seq #(.W(4), .CW(3), .SHIFT_LAT(1), .OP_NOP(3'b000)) u_dut0 (
    .clk(clk), .rst(rst),
    .cmd_valid(cv[0]), .cmd_ready(cr[0]), .cmd_data(cd[0]),
    .cmd_op(co[0]), .cmd_count(cc[0]),
    .go_data(gd[0]), .op(opo[0]), .get_data(gt[0]),
    .res_valid(rv[0]), .res_ready(rr[0]), .res_data(rd[0])
  );

  shift_cmd_seq #(.W(4), .CW(3), .SHIFT_LAT(3), .OP_NOP(3'b000)) u_dut1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cv[1]), .cmd_ready(cr[1]), .cmd_data(cd[1]),
    .cmd_op(co[1]), .cmd_count(cc[1]),
    .go_data(gd[1]), .op(opo[1]), .get_data(gt[1]),
    .res_valid(rv[1]), .res_ready(rr[1]), .res_data(rd[1])
  );

  function automatic logic [3:0] stepf(input logic [3:0] d,
                                       input logic [2:0] o);
    case (o)
      3'b010:  return {d[2:0], d[3]};
      3'b011:  return {d[0], d[3:1]};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] rotn(input logic [3:0] d,
                                      input logic [2:0] o,
                                      input int n);
    logic [3:0] r;
    r = d;
    for (int k = 0; k < n; k++) r = stepf(r, o);
    return r;
  endfunction

  // stub shifters
  logic [3:0] p1a, p1b;
  always @(posedge clk) begin
    gt[0] <= stepf(gd[0], opo[0]);
    p1a   <= stepf(gd[1], opo[1]);
    p1b   <= p1a;
    gt[1] <= p1b;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (opo[i] !== 3'b000) nissue[i]++;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // model: a command is a timeline from its acceptance cycle
  bit         m_busy[2];
  int         m_acc[2];
  logic [3:0] m_d[2];
  logic [2:0] m_o[2];
  int         m_c[2];
  logic [3:0] m_go[2];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int per, dn, t;
      per = 1 + lat_of(i);
      dn  = 1 + m_c[i] * per;
      t   = cyc - m_acc[i];
      if (rst) begin
        m_busy[i] = 0;
        m_go[i]   = 4'b0000;
      end else if (m_busy[i]) begin
        if (t >= dn && rr[i]) begin
          m_busy[i] = 0;
          if (m_c[i] > 0) m_go[i] = rotn(m_d[i], m_o[i], m_c[i] - 1);
        end
      end else if (cv[i]) begin
        m_busy[i] = 1;
        m_acc[i]  = cyc;
        m_d[i]    = cd[i];
        m_o[i]    = co[i];
        m_c[i]    = int'(cc[i]);
      end
    end
    cyc++;
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        int per, dn, t, kk;
        logic       e_rdy, e_val;
        logic [2:0] e_op;
        logic [3:0] e_go;
        per   = 1 + lat_of(i);
        dn    = 1 + m_c[i] * per;
        t     = cyc - m_acc[i];
        e_rdy = 1'b1;
        e_val = 1'b0;
        e_op  = 3'b000;
        e_go  = m_go[i];
        if (m_busy[i]) begin
          e_rdy = 1'b0;
          e_val = (t >= dn);
          if (m_c[i] > 0 && t < dn && ((t - 1) % per) == 0) e_op = m_o[i];
          if (m_c[i] > 0) begin
            kk = (t - 1) / per;
            if (kk > m_c[i] - 1) kk = m_c[i] - 1;
            e_go = rotn(m_d[i], m_o[i], kk);
          end
        end
        chk($sformatf("u%0d cmd_ready", i), 32'(cr[i]), 32'(e_rdy));
        chk($sformatf("u%0d res_valid", i), 32'(rv[i]), 32'(e_val));
        chk($sformatf("u%0d op", i), 32'(opo[i]), 32'(e_op));
        chk($sformatf("u%0d go_data", i), 32'(gd[i]), 32'(e_go));
        if (e_val)
          chk($sformatf("u%0d res_data", i), 32'(rd[i]),
              32'(rotn(m_d[i], m_o[i], m_c[i])));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [3:0] d,
                      input logic [2:0] o, input logic [2:0] c,
                      output int acc);
    cd[i] = d; co[i] = o; cc[i] = c; cv[i] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (cr[i] === 1'b1) break;
      step();
    end
    chk("accept wait", 32'(cr[i]), 32'd1);
    acc = cyc;
    step();
    cv[i] = 1'b0;
  endtask

  task automatic wait_res(input int i, input int acc, output int lat);
    for (int n = 0; n < 80; n++) begin
      if (rv[i] === 1'b1) break;
      step();
    end
    chk("result wait", 32'(rv[i]), 32'd1);
    lat = cyc - acc;
  endtask

  task automatic take(input int i);
    rr[i] = 1'b1;
    step();
    rr[i] = 1'b0;
  endtask

  initial begin
    int acc, lat, b;
    rst = 1'b1; cv = '0; rr = '0; cd = '0; co = '0; cc = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst cmd_ready", 32'(cr[0]), 32'd1);
    chk("rst res_valid", 32'(rv[0]), 32'd0);
    chk("rst op", 32'(opo[0]), 32'd0);
    chk("rst go_data", 32'(gd[0]), 32'd0);
    chk("rst res_data", 32'(rd[0]), 32'd0);

    b = nissue[0];
    send(0, 4'b1101, 3'b010, 3'd1, acc);
    wait_res(0, acc, lat);
    chk("single lat", 32'(lat), 32'd3);
    chk("single data", 32'(rd[0]), 32'b1011);
    take(0);
    chk("single issues", 32'(nissue[0] - b), 32'd1);

    b = nissue[0];
    send(0, 4'b1101, 3'b011, 3'd3, acc);
    wait_res(0, acc, lat);
    chk("multi lat", 32'(lat), 32'd7);
    chk("multi data", 32'(rd[0]), 32'b1011);
    take(0);
    chk("multi issues", 32'(nissue[0] - b), 32'd3);

    b = nissue[0];
    send(0, 4'b0110, 3'b010, 3'd0, acc);
    wait_res(0, acc, lat);
    chk("zero lat", 32'(lat), 32'd1);
    chk("zero data", 32'(rd[0]), 32'b0110);
    take(0);
    chk("zero issues", 32'(nissue[0] - b), 32'd0);

    send(0, 4'b0011, 3'b010, 3'd1, acc);
    wait_res(0, acc, lat);
    cd[0] = 4'b1000; co[0] = 3'b011; cc[0] = 3'd1; cv[0] = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      chk("bp cmd_ready", 32'(cr[0]), 32'd0);
      chk("bp res_valid", 32'(rv[0]), 32'd1);
      chk("bp res_data", 32'(rd[0]), 32'b0110);
    end
    take(0);
    chk("no bypass ready", 32'(cr[0]), 32'd1);
    chk("taken valid", 32'(rv[0]), 32'd0);
    acc = cyc;
    step();
    cv[0] = 1'b0;
    chk("second accepted", 32'(cr[0]), 32'd0);
    wait_res(0, acc, lat);
    chk("second lat", 32'(lat), 32'd3);
    chk("second data", 32'(rd[0]), 32'b0100);
    take(0);

    send(0, 4'b1101, 3'b011, 3'd3, acc);
    repeat (2) step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    chk("mid rst cmd_ready", 32'(cr[0]), 32'd1);
    chk("mid rst res_valid", 32'(rv[0]), 32'd0);
    chk("mid rst op", 32'(opo[0]), 32'd0);
    chk("mid rst go_data", 32'(gd[0]), 32'd0);
    send(0, 4'b1101, 3'b010, 3'd1, acc);
    wait_res(0, acc, lat);
    chk("post rst lat", 32'(lat), 32'd3);
    chk("post rst data", 32'(rd[0]), 32'b1011);
    take(0);

    b = nissue[1];
    send(1, 4'b0001, 3'b010, 3'd2, acc);
    wait_res(1, acc, lat);
    chk("lat3 lat", 32'(lat), 32'd9);
    chk("lat3 data", 32'(rd[1]), 32'b0100);
    take(1);
    chk("lat3 issues", 32'(nissue[1] - b), 32'd2);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
